// File: rtl/eight_to_three_encoder_pkg.sv
// Shared widths, code type and constants for the 8-to-3 priority encoder.
package enc_pkg;
  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef logic [ENC_OUT_W-1:0] enc_code_t;

  localparam enc_code_t ENC_CODE_NONE = 3'b000;
endpackage

// File: rtl/eight_to_three_encoder_if.sv
// Request/code bundle between a requester and the encoder.
// multi_hot is present only when ENCODER_MULTI_HOT_EN is defined.
interface eight_to_three_encoder_if;
  import enc_pkg::*;

  logic [ENC_IN_W-1:0] eight_input;
  enc_code_t           three_output;
  logic                V;
`ifdef ENCODER_MULTI_HOT_EN
  logic                multi_hot;
`endif

  modport master (
    output eight_input,
`ifdef ENCODER_MULTI_HOT_EN
    input  multi_hot,
`endif
    input  three_output,
    input  V
  );

  modport slave (
    input  eight_input,
`ifdef ENCODER_MULTI_HOT_EN
    output multi_hot,
`endif
    output three_output,
    output V
  );
endinterface

// File: rtl/eight_to_three_encoder_prio_comb.sv
// Purely combinational priority logic: index of highest set bit, any-set, and
// (with ENCODER_MULTI_HOT_EN) more-than-one-set.
module enc_prio_comb
  import enc_pkg::*;
(
  input  logic [ENC_IN_W-1:0] eight_input,
`ifdef ENCODER_MULTI_HOT_EN
  output logic                multi,
`endif
  output enc_code_t           code,
  output logic                any
);

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    code = ENC_CODE_NONE;
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (eight_input[i]) begin
        code = enc_code_t'(i);
      end
    end
  end

  assign any = |eight_input;

`ifdef ENCODER_MULTI_HOT_EN
  assign multi = ($countones(eight_input) > 1);
`endif

endmodule

// File: rtl/eight_to_three_encoder.sv
// Registered 8-to-3 priority encoder, 1-cycle latency, no stall; outputs clear
// asynchronously on rst_n low. Optional multi_hot output under ENCODER_MULTI_HOT_EN.
module eight_to_three_encoder
  import enc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  eight_to_three_encoder_if.slave bus
);

  localparam int IN_W  = ENC_IN_W;
  localparam int OUT_W = ENC_OUT_W;

  logic [OUT_W-1:0] w_code;
  logic             w_any;
  logic [OUT_W-1:0] r_code;
  logic             r_v;
  logic [IN_W-1:0]  w_in;

  assign w_in = bus.eight_input;

`ifdef ENCODER_MULTI_HOT_EN
  logic w_multi;
  logic r_multi;

  enc_prio_comb u_prio (
    .eight_input (w_in),
    .multi       (w_multi),
    .code        (w_code),
    .any         (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_multi <= 1'b0;
    end else begin
      r_multi <= w_multi;
    end
  end

  assign bus.multi_hot = r_multi;
`else
  enc_prio_comb u_prio (
    .eight_input (w_in),
    .code        (w_code),
    .any         (w_any)
  );
`endif

  // Code and valid share one register stage so they always change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= ENC_CODE_NONE;
      r_v    <= 1'b0;
    end else begin
      r_code <= w_code;
      r_v    <= w_any;
    end
  end

  assign bus.three_output = r_code;
  assign bus.V            = r_v;

endmodule

// File: tb/tb_eight_to_three_encoder.sv
// Directed self-checking bench for eight_to_three_encoder; multi_hot checks are
// compiled in only with ENCODER_MULTI_HOT_EN.
module tb_eight_to_three_encoder;
  import enc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  eight_to_three_encoder_if bus ();

  eight_to_three_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected code, V and multi_hot for one sampled output set.
  task automatic check_out(input string tag, input logic [2:0] code, input logic v,
                           input logic multi);
    check_eq({tag, "_code"}, {5'd0, bus.three_output}, {5'd0, code});
    check_eq({tag, "_v"},    {7'd0, bus.V},            {7'd0, v});
`ifdef ENCODER_MULTI_HOT_EN
    check_eq({tag, "_multi"}, {7'd0, bus.multi_hot},   {7'd0, multi});
`else
    if (multi === 1'bx) n_checks = n_checks + 0;
`endif
  endtask

  // Drive on the falling edge, sample 1 ns after the next rising edge.
  task automatic apply(input string tag, input logic [7:0] val, input logic [2:0] code,
                       input logic v, input logic multi);
    @(negedge clk);
    bus.eight_input = val;
    @(posedge clk);
    #1;
    check_out(tag, code, v, multi);
  endtask

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    rst_n           = 1'b0;
    bus.eight_input = 8'hFF;

    // Reset with all inputs set, before any clock edge.
    #1;
    check_out("rst_noedge", 3'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_out("rst_hold", 3'd0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    apply("zero",  8'h00, 3'd0, 1'b0, 1'b0);
    apply("walk0", 8'h01, 3'd0, 1'b1, 1'b0);
    apply("walk1", 8'h02, 3'd1, 1'b1, 1'b0);
    apply("walk2", 8'h04, 3'd2, 1'b1, 1'b0);
    apply("walk7", 8'h80, 3'd7, 1'b1, 1'b0);
    apply("prioC0", 8'hC0, 3'd7, 1'b1, 1'b1);
    apply("prio03", 8'h03, 3'd1, 1'b1, 1'b1);
    apply("prio28", 8'h28, 3'd5, 1'b1, 1'b1);
    apply("bit0",  8'h01, 3'd0, 1'b1, 1'b0);
    apply("allset", 8'hFF, 3'd7, 1'b1, 1'b1);
    apply("zero2", 8'h00, 3'd0, 1'b0, 1'b0);

    // Mid-stream reset pulse between edges.
    apply("pre_rst", 8'h10, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 3'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst", 3'd4, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
